// File: rtl/acquisition_sequencer.sv
// acquisition_sequencer: capture/readout sequencer; define ACQ_SEQ_CH2_EN to enable channel-2 readout
module acquisition_sequencer #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DATA_WIDTH = 8,
  parameter int TX_DATA_WIDTH = 8,
  parameter int ADDR_REQUESTS = 2,
  parameter int ADDR_NUM_SAMPLES_L = 3,
  parameter int ADDR_NUM_SAMPLES_H = 4,
  parameter int DEFAULT_NUM_SAMPLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
  input  logic [REG_DATA_WIDTH-1:0] reg_data,
  input  logic                      reg_rdy,
  input  logic                      adc_rdy,
  input  logic                      trigger,
  output logic                      we,
  output logic [15:0]               num_samples,
  output logic                      rqst_ch1,
  output logic                      rqst_ch2,
  input  logic [TX_DATA_WIDTH-1:0]  ch1_data,
  input  logic                      ch1_rdy,
  input  logic                      ch1_eof,
  output logic                      ch1_ack,
  input  logic [TX_DATA_WIDTH-1:0]  ch2_data,
  input  logic                      ch2_rdy,
  input  logic                      ch2_eof,
  output logic                      ch2_ack,
  output logic [TX_DATA_WIDTH-1:0]  tx_data,
  output logic                      tx_rdy,
  output logic                      tx_eof,
  input  logic                      tx_ack,
  output logic                      busy
);
  typedef enum logic [2:0] {IDLE, ARMED, POST, REQ1, READ1, REQ2, READ2} state_t;
`ifdef ACQ_SEQ_CH2_EN
  localparam logic CH2_EN = 1'b1;
`else
  localparam logic CH2_EN = 1'b0;
`endif
  state_t      r_state, w_next, w_read_first;
  logic        r_we, r_sel1, r_sel2;
  logic [15:0] r_num_samples, r_post, r_cnt;
  logic        w_cmd, w_start, w_stop, w_rd1, w_rd2, w_done1, w_done2;
  assign w_cmd   = reg_rdy && reg_addr == REG_ADDR_WIDTH'(ADDR_REQUESTS);
  assign w_start = w_cmd && reg_data[0];
  assign w_stop  = w_cmd && reg_data[1];
  assign w_rd1   = r_state == READ1;
  assign w_rd2   = r_state == READ2;
  assign w_done1 = ch1_rdy && ch1_eof && tx_ack;
  assign w_done2 = ch2_rdy && ch2_eof && tx_ack;
  assign w_read_first = r_sel1 ? REQ1 : r_sel2 ? REQ2 : IDLE;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_start ? ARMED : IDLE;
      ARMED:   w_next = w_stop ? IDLE : !trigger ? ARMED : r_post == 16'd0 ? w_read_first : POST;
      POST:    w_next = w_stop ? IDLE : r_cnt == r_post ? w_read_first : POST;
      REQ1:    w_next = READ1;
      READ1:   w_next = !w_done1 ? READ1 : r_sel2 ? REQ2 : IDLE;
      REQ2:    w_next = READ2;
      READ2:   w_next = w_done2 ? IDLE : READ2;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_we          <= 1'b0;
      r_sel1        <= 1'b0;
      r_sel2        <= 1'b0;
      r_post        <= '0;
      r_cnt         <= '0;
      r_num_samples <= 16'(DEFAULT_NUM_SAMPLES);
    end else begin
      r_state <= w_next;
      r_we    <= w_next == ARMED || w_next == POST;
      if (reg_rdy && reg_addr == REG_ADDR_WIDTH'(ADDR_NUM_SAMPLES_L))
        r_num_samples[7:0] <= reg_data[7:0];
      if (reg_rdy && reg_addr == REG_ADDR_WIDTH'(ADDR_NUM_SAMPLES_H))
        r_num_samples[15:8] <= reg_data[7:0];
      if (r_state == IDLE && w_start) begin
        r_sel1 <= reg_data[2];
        r_sel2 <= CH2_EN && reg_data[3];
        r_post <= r_num_samples;
      end
      if (r_state == ARMED && trigger)
        r_cnt <= '0;
      else if (r_state == POST && adc_rdy && r_cnt != r_post)
        r_cnt <= r_cnt + 16'd1;
    end
  end
  assign we          = r_we;
  assign num_samples = r_num_samples;
  assign busy        = r_state != IDLE;
  assign rqst_ch1    = r_state == REQ1;
  assign rqst_ch2    = r_state == REQ2;
  assign tx_data     = w_rd1 ? ch1_data : w_rd2 ? ch2_data : '0;
  assign tx_rdy      = w_rd1 ? ch1_rdy : w_rd2 && ch2_rdy;
  assign tx_eof      = w_rd1 ? ch1_eof : w_rd2 && ch2_eof;
  assign ch1_ack     = w_rd1 && tx_ack;
  assign ch2_ack     = w_rd2 && tx_ack;
endmodule

// File: tb/tb_acquisition_sequencer.sv
// tb_acquisition_sequencer: directed checks of capture, readout, stop and reset behaviour
module tb_acquisition_sequencer;
  logic        clk = 1'b0, rst = 1'b0;
  logic [4:0]  reg_addr = '0;
  logic [7:0]  reg_data = '0;
  logic        reg_rdy = 1'b0, adc_rdy = 1'b0, trigger = 1'b0;
  logic        we, rqst_ch1, rqst_ch2, ch1_ack, ch2_ack, tx_rdy, tx_eof, busy;
  logic [15:0] num_samples;
  logic [7:0]  ch1_data = '0, ch2_data = '0, tx_data;
  logic        ch1_rdy = 1'b0, ch1_eof = 1'b0, ch2_rdy = 1'b0, ch2_eof = 1'b0, tx_ack = 1'b0;
  int          n_chk = 0, n_err = 0, n_r1 = 0, n_r2 = 0, base1, base2;
  acquisition_sequencer dut (
    .clk(clk), .rst(rst), .reg_addr(reg_addr), .reg_data(reg_data), .reg_rdy(reg_rdy),
    .adc_rdy(adc_rdy), .trigger(trigger), .we(we), .num_samples(num_samples),
    .rqst_ch1(rqst_ch1), .rqst_ch2(rqst_ch2),
    .ch1_data(ch1_data), .ch1_rdy(ch1_rdy), .ch1_eof(ch1_eof), .ch1_ack(ch1_ack),
    .ch2_data(ch2_data), .ch2_rdy(ch2_rdy), .ch2_eof(ch2_eof), .ch2_ack(ch2_ack),
    .tx_data(tx_data), .tx_rdy(tx_rdy), .tx_eof(tx_eof), .tx_ack(tx_ack), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rqst_ch1) n_r1++;
    if (rqst_ch2) n_r2++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic reg_wr(input logic [4:0] a, input logic [7:0] d);
    reg_addr = a;
    reg_data = d;
    reg_rdy = 1'b1;
    tick();
    reg_rdy = 1'b0;
  endtask
  task automatic pulse_trigger();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask
  task automatic ch1_beat(input logic [7:0] d, input logic eof, input logic ack);
    ch1_data = d;
    ch1_rdy = 1'b1;
    ch1_eof = eof;
    tx_ack = ack;
    #1;
    check("ch1_tx_data", tx_data, d);
    check("ch1_tx_rdy", tx_rdy, 1);
    check("ch1_tx_eof", tx_eof, eof);
    check("ch1_ack", ch1_ack, ack);
    check("ch2_ack_in_read1", ch2_ack, 0);
    tick();
    ch1_rdy = 1'b0;
    ch1_eof = 1'b0;
    tx_ack = 1'b0;
  endtask
  initial begin
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_we", we, 0);
    check("rst_num_samples", num_samples, 1024);
    check("rst_rqst", {rqst_ch1, rqst_ch2}, 0);
    rst = 1'b1;
    tick();
    // Single-channel capture of 4 samples followed by a 3-byte readout
    reg_wr(5'd3, 8'd4);
    reg_wr(5'd4, 8'd0);
    check("ns_write", num_samples, 4);
    base1 = n_r1;
    reg_wr(5'd2, 8'h05);
    check("armed_busy", busy, 1);
    check("armed_we", we, 1);
    tick();
    pulse_trigger();
    check("post_we", we, 1);
    for (int i = 0; i < 4; i++) begin
      adc_rdy = 1'b1;
      tick();
      adc_rdy = 1'b0;
      if (i < 3) tick();
    end
    check("post_end_we", we, 1);
    check("post_end_rqst", rqst_ch1, 0);
    tick();
    check("req1_rqst", rqst_ch1, 1);
    check("req1_we", we, 0);
    tick();
    check("read1_rqst_off", rqst_ch1, 0);
    ch1_beat(8'hA0, 1'b1, 1'b0);
    check("read1_hold_busy", busy, 1);
    for (int i = 0; i < 3; i++) ch1_beat(8'hA0 + 8'(i), i == 2, 1'b1);
    #1;
    check("done_busy", busy, 0);
    check("done_tx_rdy", tx_rdy, 0);
    check("done_rqst1_count", n_r1 - base1, 1);
    // Count written while armed must not change the capture length
    reg_wr(5'd3, 8'd2);
    reg_wr(5'd2, 8'h05);
    reg_wr(5'd3, 8'd9);
    check("ns_rewrite", num_samples, 9);
    pulse_trigger();
    for (int i = 0; i < 2; i++) begin
      adc_rdy = 1'b1;
      tick();
      adc_rdy = 1'b0;
    end
    check("latched_post_we", we, 1);
    tick();
    check("latched_req1", rqst_ch1, 1);
    tick();
    ch1_beat(8'h11, 1'b1, 1'b1);
    #1;
    check("latched_done", busy, 0);
    // Zero count: request the cycle after trigger, no samples
    reg_wr(5'd3, 8'd0);
    reg_wr(5'd2, 8'h05);
    pulse_trigger();
    check("zero_rqst", rqst_ch1, 1);
    check("zero_we", we, 0);
    tick();
    ch1_beat(8'h33, 1'b1, 1'b1);
    #1;
    check("zero_done", busy, 0);
    // STOP with trigger in ARMED
    base1 = n_r1;
    base2 = n_r2;
    reg_wr(5'd2, 8'h0D);
    check("stop_armed_we", we, 1);
    reg_addr = 5'd2;
    reg_data = 8'h02;
    reg_rdy = 1'b1;
    trigger = 1'b1;
    tick();
    reg_rdy = 1'b0;
    trigger = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_we", we, 0);
    repeat (3) tick();
    check("stop_no_rqst", (n_r1 - base1) + (n_r2 - base2), 0);
    // Two-channel readout, or ignored channel-2 select
    base1 = n_r1;
    base2 = n_r2;
`ifdef ACQ_SEQ_CH2_EN
    reg_wr(5'd2, 8'h0D);
    pulse_trigger();
    check("dual_req1", rqst_ch1, 1);
    tick();
    ch1_beat(8'h51, 1'b0, 1'b1);
    ch1_beat(8'h52, 1'b1, 1'b1);
    #1;
    check("dual_req2", rqst_ch2, 1);
    check("dual_req2_no_r1", rqst_ch1, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      ch2_data = 8'h60 + 8'(i);
      ch2_rdy = 1'b1;
      ch2_eof = i == 1;
      ch1_rdy = 1'b1;
      tx_ack = 1'b1;
      #1;
      check("dual_tx_data", tx_data, 8'h60 + 8'(i));
      check("dual_tx_eof", tx_eof, i == 1);
      check("dual_ch2_ack", ch2_ack, 1);
      check("dual_ch1_ack", ch1_ack, 0);
      tick();
    end
    {ch2_rdy, ch2_eof, ch1_rdy, tx_ack} = '0;
    #1;
    check("dual_done", busy, 0);
    check("dual_rqst_counts", {16'(n_r1 - base1), 16'(n_r2 - base2)}, {16'd1, 16'd1});
`else
    reg_wr(5'd2, 8'h09);
    pulse_trigger();
    check("nch2_done", busy, 0);
    tick();
    check("nch2_no_rqst", (n_r1 - base1) + (n_r2 - base2), 0);
    check("nch2_ack", ch2_ack, 0);
`endif
    // Reset in the middle of a channel-1 transfer
    reg_wr(5'd2, 8'h05);
    pulse_trigger();
    tick();
    ch1_data = 8'h77;
    ch1_rdy = 1'b1;
    tx_ack = 1'b1;
    #1;
    check("midrst_pre_rdy", tx_rdy, 1);
    rst = 1'b0;
    tick();
    check("midrst_tx_rdy", tx_rdy, 0);
    check("midrst_ack", ch1_ack, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ns", num_samples, 1024);
    rst = 1'b1;
    ch1_rdy = 1'b0;
    tx_ack = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
